// File: rtl/fk_sched_pkg.sv
// Shared definitions for the PLL-setup hop scheduler: state encoding,
// requester indices and datapath widths.
package fk_sched_pkg;

  localparam int CHAN_W = 7;
  localparam int NREQ   = 4;
  localparam int WDOG_W = 10;
  localparam logic [WDOG_W-1:0] WDOG_MAX = 10'd1023;

  localparam int REQ_CONN = 0;
  localparam int REQ_MPR  = 1;
  localparam int REQ_SPR  = 2;
  localparam int REQ_INQ  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CALC,
    HOLD,
    LOAD
  } fk_state_e;

endpackage

// File: rtl/fk_prio_arb.sv
// Fixed-priority one-hot encoder for the hop-compute requesters.
// Slave page response wins, then master page response, connection, inquiry.
module fk_prio_arb
  import fk_sched_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[REQ_SPR]) begin
      gnt_o[REQ_SPR] = 1'b1;
    end else if (req_i[REQ_MPR]) begin
      gnt_o[REQ_MPR] = 1'b1;
    end else if (req_i[REQ_CONN]) begin
      gnt_o[REQ_CONN] = 1'b1;
    end else if (req_i[REQ_INQ]) begin
      gnt_o[REQ_INQ] = 1'b1;
    end
  end

endmodule

// File: rtl/fk_sched.sv
// Schedules hop-channel computation on the shared kernel and loads the
// result into the PLL at the next clean setup deadline.
module fk_sched
  import fk_sched_pkg::*;
(
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              fkset_p,
  input  logic              txbit_period,
  input  logic              rxbit_period,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic              hs_start,
  input  logic              hs_done,
  input  logic [CHAN_W-1:0] hs_chan,
  output logic              pll_load,
  output logic [CHAN_W-1:0] pll_chan,
  output logic              sched_miss,
  output logic [7:0]        load_cnt
);

  fk_state_e         state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   arb_gnt;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [CHAN_W-1:0] pll_chan_q, pll_chan_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [7:0]        load_cnt_q, load_cnt_d;
  logic              fk_chg_p;
  logic              owner_lost;
  logic              wdog_expired;

  fk_prio_arb u_arb (
    .req_i (req),
    .gnt_o (arb_gnt)
  );

  assign fk_chg_p     = fkset_p & ~(txbit_period | rxbit_period);
  assign owner_lost   = ~|(req & grant_q);
  assign wdog_expired = (wdog_q == WDOG_MAX);
  assign load_cnt     = load_cnt_q;

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      chan_q     <= '0;
      pll_chan_q <= '0;
      wdog_q     <= '0;
      load_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      chan_q     <= chan_d;
      pll_chan_q <= pll_chan_d;
      wdog_q     <= wdog_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    chan_d     = chan_q;
    pll_chan_d = pll_chan_q;
    wdog_d     = wdog_q;
    load_cnt_d = load_cnt_q;
    grant      = '0;
    hs_start   = 1'b0;
    pll_load   = 1'b0;
    pll_chan   = pll_chan_q;
    sched_miss = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ARB;
        end
      end

      ARB: begin
        grant    = arb_gnt;
        grant_d  = arb_gnt;
        hs_start = 1'b1;
        wdog_d   = '0;
        state_d  = CALC;
      end

      // A deadline seen while the kernel is still busy is flagged but the
      // result is still loaded at a later clean deadline.
      CALC: begin
        grant      = grant_q;
        sched_miss = fkset_p | (wdog_expired & ~hs_done);
        if (owner_lost) begin
          state_d = IDLE;
        end else if (hs_done) begin
          chan_d  = hs_chan;
          state_d = HOLD;
        end else if (wdog_expired) begin
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      HOLD: begin
        grant = grant_q;
        if (owner_lost) begin
          state_d = IDLE;
        end else if (fk_chg_p) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        grant      = grant_q;
        pll_load   = 1'b1;
        pll_chan   = chan_q;
        pll_chan_d = chan_q;
        load_cnt_d = load_cnt_q + 8'd1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fk_sched.sv
// Randomized and directed bench for fk_sched, checked every cycle against a
// transaction-level reference model of the scheduler.
module tb_fk_sched;

  logic       clk_6M = 1'b0;
  logic       rstz;
  logic       fkset_p;
  logic       txbit_period;
  logic       rxbit_period;
  logic [3:0] req;
  logic [3:0] grant;
  logic       hs_start;
  logic       hs_done;
  logic [6:0] hs_chan;
  logic       pll_load;
  logic [6:0] pll_chan;
  logic       sched_miss;
  logic [7:0] load_cnt;

  localparam int P_IDLE = 0;
  localparam int P_ARB  = 1;
  localparam int P_CALC = 2;
  localparam int P_HOLD = 3;
  localparam int P_LOAD = 4;

  int checks = 0;
  int errors = 0;

  logic [3:0] rqV;
  logic       fkV, txV, rxV, dnV, rstV;
  logic [6:0] chV;

  int         mPhase, mOwner, mWd;
  logic [6:0] mChan, mPll;
  logic [7:0] mCnt;

  logic [3:0] oGrant;
  logic       oStart, oLoad, oMiss;
  logic [6:0] oChan;
  logic [7:0] oCnt;
  int         nLoads = 0;
  int         nMiss = 0;
  logic [6:0] lastLoadChan = '0;
  logic [3:0] startGrant = '0;

  fk_sched dut (
    .clk_6M       (clk_6M),
    .rstz         (rstz),
    .fkset_p      (fkset_p),
    .txbit_period (txbit_period),
    .rxbit_period (rxbit_period),
    .req          (req),
    .grant        (grant),
    .hs_start     (hs_start),
    .hs_done      (hs_done),
    .hs_chan      (hs_chan),
    .pll_load     (pll_load),
    .pll_chan     (pll_chan),
    .sched_miss   (sched_miss),
    .load_cnt     (load_cnt)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int prioPick(input logic [3:0] r);
    int order [4];
    order = '{2, 1, 0, 3};
    for (int i = 0; i < 4; i++) begin
      if (r[order[i]]) return order[i];
    end
    return -1;
  endfunction

  function automatic logic [3:0] oneHot(input int idx);
    if (idx < 0) return 4'b0000;
    return 4'b0001 << idx;
  endfunction

  task automatic modelReset();
    mPhase = P_IDLE;
    mOwner = -1;
    mWd    = 0;
    mChan  = '0;
    mPll   = '0;
    mCnt   = '0;
  endtask

  // Advance the reference model by one clock using this cycle's inputs.
  task automatic modelStep();
    bit ownerGone;
    ownerGone = (mOwner < 0) || !rqV[mOwner];
    if (!rstV) begin
      modelReset();
    end else begin
      case (mPhase)
        P_IDLE: if (rqV != 4'b0) mPhase = P_ARB;
        P_ARB: begin
          mOwner = prioPick(rqV);
          mWd    = 0;
          mPhase = P_CALC;
        end
        P_CALC: begin
          if (ownerGone) mPhase = P_IDLE;
          else if (dnV) begin
            mChan  = chV;
            mPhase = P_HOLD;
          end else if (mWd >= 1023) mPhase = P_IDLE;
          else mWd++;
        end
        P_HOLD: begin
          if (ownerGone) mPhase = P_IDLE;
          else if (fkV && !txV && !rxV) mPhase = P_LOAD;
        end
        default: begin
          mPll   = mChan;
          mCnt   = mCnt + 8'd1;
          mPhase = P_IDLE;
        end
      endcase
    end
  endtask

  // One clock: drive inputs, compare every output at the falling edge,
  // then step the model on the rising edge.
  task automatic applyStimulus();
    logic [3:0] eGrant;
    logic       eStart, eLoad, eMiss;
    logic [6:0] eChan;
    rstz = rstV; req = rqV; fkset_p = fkV; txbit_period = txV;
    rxbit_period = rxV; hs_done = dnV; hs_chan = chV;
    @(negedge clk_6M);
    oGrant = grant; oStart = hs_start; oLoad = pll_load; oMiss = sched_miss;
    oChan = pll_chan; oCnt = load_cnt;
    eGrant = 4'b0; eStart = 1'b0; eLoad = 1'b0; eMiss = 1'b0; eChan = mPll;
    case (mPhase)
      P_ARB: begin
        eGrant = oneHot(prioPick(rqV));
        eStart = 1'b1;
      end
      P_CALC: begin
        eGrant = oneHot(mOwner);
        eMiss  = fkV || (mWd >= 1023 && !dnV);
      end
      P_HOLD: eGrant = oneHot(mOwner);
      P_LOAD: begin
        eGrant = oneHot(mOwner);
        eLoad  = 1'b1;
        eChan  = mChan;
      end
      default: ;
    endcase
    checkOutput("grant", oGrant, eGrant);
    checkOutput("hs_start", oStart, eStart);
    checkOutput("pll_load", oLoad, eLoad);
    checkOutput("sched_miss", oMiss, eMiss);
    checkOutput("pll_chan", oChan, eChan);
    checkOutput("load_cnt", oCnt, mCnt);
    if (oLoad) begin
      nLoads++;
      lastLoadChan = oChan;
    end
    if (oMiss) nMiss++;
    if (oStart) startGrant = oGrant;
    @(posedge clk_6M);
    modelStep();
    #1;
    fkV = 1'b0;
    dnV = 1'b0;
  endtask

  task automatic serve(input logic [3:0] r, input int doneLat, input logic [6:0] ch, input int fkLat);
    rqV = r;
    applyStimulus();
    applyStimulus();
    repeat (doneLat - 1) applyStimulus();
    dnV = 1'b1;
    chV = ch;
    applyStimulus();
    repeat (fkLat - 1) applyStimulus();
    fkV = 1'b1;
    applyStimulus();
    rqV = 4'b0;
    applyStimulus();
  endtask

  initial begin
    int l0, m0, k;
    rstV = 1'b0; rqV = '0; fkV = 1'b0; txV = 1'b0; rxV = 1'b0; dnV = 1'b0; chV = '0;
    rstz = 1'b0; req = '0; fkset_p = 1'b0; txbit_period = 1'b0; rxbit_period = 1'b0;
    hs_done = 1'b0; hs_chan = '0;
    modelReset();
    @(posedge clk_6M);
    #1;

    applyStimulus();
    checkOutput("rstGrant", oGrant, 4'b0);
    checkOutput("rstCnt", oCnt, 8'd0);
    rstV = 1'b1;
    applyStimulus();

    // Basic service with priority between two simultaneous requesters.
    l0 = nLoads;
    serve(4'b0110, 3, 7'd45, 20);
    applyStimulus();
    checkOutput("basicGrant", startGrant, 4'b0100);
    checkOutput("basicLoads", nLoads - l0, 1);
    checkOutput("basicChan", lastLoadChan, 7'd45);
    checkOutput("basicCnt", oCnt, 8'd1);

    // Kernel never answers: watchdog abandons the request.
    l0 = nLoads;
    rqV = 4'b0001;
    applyStimulus();
    k = 0;
    for (int i = 0; i < 1100; i++) begin
      applyStimulus();
      k++;
      if (oMiss) break;
    end
    checkOutput("wdogSeen", oMiss, 1'b1);
    checkOutput("wdogLatency", (k - 1 >= 1023 && k - 1 <= 1024), 1'b1);
    rqV = 4'b0;
    applyStimulus();
    checkOutput("wdogIdle", oGrant, 4'b0);
    checkOutput("wdogNoLoad", nLoads - l0, 0);
    checkOutput("wdogChan", oChan, 7'd45);

    // Deadline blocked by TX activity, next clean deadline loads.
    rqV = 4'b0001;
    applyStimulus();
    applyStimulus();
    dnV = 1'b1; chV = 7'd77;
    applyStimulus();
    applyStimulus();
    l0 = nLoads;
    fkV = 1'b1; txV = 1'b1;
    applyStimulus();
    txV = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("txSkip", nLoads - l0, 0);
    fkV = 1'b1;
    applyStimulus();
    rqV = 4'b0;
    applyStimulus();
    checkOutput("txLoad", nLoads - l0, 1);
    checkOutput("txChan", lastLoadChan, 7'd77);

    // Deadline during computation is flagged, result loads later.
    l0 = nLoads; m0 = nMiss;
    rqV = 4'b0100;
    applyStimulus();
    applyStimulus();
    fkV = 1'b1;
    applyStimulus();
    checkOutput("calcMiss", oMiss, 1'b1);
    applyStimulus();
    dnV = 1'b1; chV = 7'd12;
    applyStimulus();
    applyStimulus();
    fkV = 1'b1;
    applyStimulus();
    rqV = 4'b0;
    applyStimulus();
    checkOutput("calcMissCnt", nMiss - m0, 1);
    checkOutput("calcLoad", nLoads - l0, 1);
    checkOutput("calcChan", lastLoadChan, 7'd12);

    // Owner withdraws in HOLD; the pending inquiry is served next.
    l0 = nLoads;
    rqV = 4'b1010;
    applyStimulus();
    applyStimulus();
    checkOutput("dropFirst", startGrant, 4'b0010);
    dnV = 1'b1; chV = 7'd3;
    applyStimulus();
    rqV = 4'b1000;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("dropNext", startGrant, 4'b1000);
    checkOutput("dropNoLoad", nLoads - l0, 0);
    dnV = 1'b1; chV = 7'd100;
    applyStimulus();
    fkV = 1'b1;
    applyStimulus();
    rqV = 4'b0;
    applyStimulus();
    checkOutput("inqChan", lastLoadChan, 7'd100);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) rqV = 4'($urandom);
      fkV  = ($urandom_range(7) == 0);
      txV  = ($urandom_range(3) == 0);
      rxV  = ($urandom_range(3) == 0);
      dnV  = ($urandom_range(3) == 0);
      chV  = 7'($urandom);
      rstV = ($urandom_range(199) != 0);
      applyStimulus();
    end
    rstV = 1'b0; rqV = 4'b0; txV = 1'b0; rxV = 1'b0;
    applyStimulus();
    rstV = 1'b1;

    // Reset while holding a channel, then load counter wrap.
    rqV = 4'b0001;
    applyStimulus();
    applyStimulus();
    dnV = 1'b1; chV = 7'd99;
    applyStimulus();
    applyStimulus();
    rstV = 1'b0;
    applyStimulus();
    rstV = 1'b1; rqV = 4'b0;
    applyStimulus();
    checkOutput("postRstGrant", oGrant, 4'b0);
    checkOutput("postRstStart", oStart, 1'b0);
    checkOutput("postRstLoad", oLoad, 1'b0);
    checkOutput("postRstMiss", oMiss, 1'b0);
    checkOutput("postRstChan", oChan, 7'd0);
    checkOutput("postRstCnt", oCnt, 8'd0);
    l0 = nLoads;
    fkV = 1'b1; dnV = 1'b1; chV = 7'd55;
    applyStimulus();
    repeat (3) applyStimulus();
    checkOutput("postRstNoLoad", nLoads - l0, 0);
    for (int i = 0; i < 255; i++) serve(4'b0001, 1, 7'(i), 1);
    applyStimulus();
    checkOutput("cnt255", oCnt, 8'd255);
    serve(4'b0001, 1, 7'd9, 1);
    applyStimulus();
    checkOutput("cntWrap", oCnt, 8'd0);
    checkOutput("wrapLoads", nLoads - l0, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
